mul_sequencer: RTL

- Iterative shift-add multiply unit that executes MUL/MULS/UMULL for the multicycle core.
- Sits beside the ALU. The main controller FSM raises start on a multiply decode, then holds its execute state while busy is high.
- On done it writes the result back through the normal ResultSrc path. ALU flags N/Z come from this block for MULS.

---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_datapath.sv | 36 +++
 rtl/mul_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/mul_datapath.sv
// Multiplicand/partial-product registers with the shift-add step.
module mul_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH-1:0]   md;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     sum;

  // Upper half accumulates with carry; the carry is shifted back in so nothing is lost.
  always_comb begin
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, md} : '0);
    p_next = {sum, p[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md <= '0;
      p  <= '0;
    end else if (load) begin
      md <= a;
      p  <= {{WIDTH{1'b0}}, b};
    end else if (step) begin
      p  <= p_next;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Fixed-latency multiply sequencer: FSM, iteration counter and registered results/flags.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long_mul,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               lmul;
  logic               load, step, last;
  logic [2*WIDTH-1:0] p_next;

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .a      (SrcA),
    .b      (SrcB),
    .p_next (p_next)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last      = (count == CNT_W'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are captured from the final step value so they are valid during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      lmul     <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= 2'b01;
    end else begin
      state <= state_nxt;
      if (load) begin
        count <= '0;
        lmul  <= long_mul;
      end else if (step) begin
        count <= count + CNT_W'(1);
      end
      if (step && last) begin
        ResultLo <= p_next[WIDTH-1:0];
        ResultHi <= lmul ? p_next[2*WIDTH-1:WIDTH] : '0;
        MulFlags[FLAG_N] <= lmul ? p_next[2*WIDTH-1] : p_next[WIDTH-1];
        MulFlags[FLAG_Z] <= lmul ? (p_next == '0) : (p_next[WIDTH-1:0] == '0);
      end
    end
  end

endmodule
